// File: rtl/filtro_pb_seq.sv
// Multi-channel sliding-window ones-counter with hysteresis decision.
// Windows share one strobe, one clear and one fill/run state machine.
module filtro_pb_seq #(
   parameter int SAMPLES = 2,
   parameter int OSF     = 8,
   parameter int CH      = 1,
   parameter int TH_HI   = 10,
   parameter int TH_LO   = 5,
   localparam int W      = SAMPLES * OSF,
   localparam int CW     = $clog2(W) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             P,
   input  logic [CH-1:0]    DataIn,
   input  logic             clr,
   output logic [CH*CW-1:0] DataOut,
   output logic [CH-1:0]    Dec,
   output logic             Valid,
   output logic             Full
);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t          state;
   logic [CW-1:0]   fcnt;
   logic [W-1:0]    win [CH];
   logic [CW-1:0]   cnt [CH];
   logic [CW-1:0]   nxt [CH];
   logic            go_run;

   // The oldest bit only leaves the count once the window is full.
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         nxt[c] = cnt[c] + CW'(DataIn[c])
                - ((state == RUN) ? CW'(win[c][W-1]) : CW'(0));
      end
   end

   always_comb begin
      go_run = (state == RUN)
            || (state == FILL && fcnt == CW'(W - 1))
            || (state == IDLE && W == 1);
   end

   always_comb begin
      DataOut = '0;
      for (int c = 0; c < CH; c++) begin
         DataOut[c*CW +: CW] = cnt[c];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         fcnt  <= '0;
         Valid <= 1'b0;
         Full  <= 1'b0;
         Dec   <= '0;
         for (int c = 0; c < CH; c++) begin
            win[c] <= '0;
            cnt[c] <= '0;
         end
      end else if (clr) begin
         state <= IDLE;
         fcnt  <= '0;
         Valid <= 1'b0;
         Full  <= 1'b0;
         Dec   <= '0;
         for (int c = 0; c < CH; c++) begin
            win[c] <= '0;
            cnt[c] <= '0;
         end
      end else begin
         Valid <= 1'b0;
         if (P) begin
            for (int c = 0; c < CH; c++) begin
               win[c] <= W'({win[c], DataIn[c]});
               cnt[c] <= nxt[c];
               if (!go_run)
                  Dec[c] <= 1'b0;
               else if (nxt[c] >= CW'(TH_HI))
                  Dec[c] <= 1'b1;
               else if (nxt[c] <= CW'(TH_LO))
                  Dec[c] <= 1'b0;
            end
            if (go_run) begin
               state <= RUN;
               fcnt  <= CW'(W);
               Full  <= 1'b1;
               Valid <= 1'b1;
            end else begin
               state <= FILL;
               fcnt  <= fcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_filtro_pb_seq.sv
// Directed bench for filtro_pb_seq with two channels and default window.
// Inputs change on the falling edge; outputs are checked 1 ns after rising.
module tb_filtro_pb_seq;

   localparam int CH = 2;
   localparam int CW = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             P = 1'b0;
   logic             clr = 1'b0;
   logic [CH-1:0]    DataIn = '0;
   logic [CH*CW-1:0] DataOut;
   logic [CH-1:0]    Dec;
   logic             Valid;
   logic             Full;

   int total = 0;
   int bad = 0;

   filtro_pb_seq #(.SAMPLES(2), .OSF(8), .CH(CH), .TH_HI(10), .TH_LO(5)) dut (
      .clk(clk), .rst(rst), .P(P), .DataIn(DataIn), .clr(clr),
      .DataOut(DataOut), .Dec(Dec), .Valid(Valid), .Full(Full)
   );

   always #5 clk = ~clk;

   task automatic strobe(input logic [1:0] d);
      @(negedge clk);
      P = 1'b1;
      DataIn = d;
      @(posedge clk);
      #1;
      P = 1'b0;
   endtask

   task automatic test_reset;
      logic [4:0] e;
      repeat (2) @(negedge clk);
      total++;
      if ({DataOut, Dec, Valid, Full} !== '0) begin
         bad++;
         $display("FAIL reset_init: out=%h dec=%b v=%b f=%b want 0",
                  DataOut, Dec, Valid, Full);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) strobe(2'b11);
      e = 5'd16;
      total++;
      if (DataOut !== {e, e} || Full !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset: out=%h full=%b want %h 1",
                  DataOut, Full, {e, e});
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({DataOut, Dec, Valid, Full} !== '0) begin
         bad++;
         $display("FAIL async_reset: out=%h dec=%b v=%b f=%b want 0",
                  DataOut, Dec, Valid, Full);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill;
      logic [4:0] e;
      logic       last;
      for (int i = 1; i <= 16; i++) begin
         strobe(2'b11);
         e = 5'(i);
         last = (i == 16);
         total++;
         if (DataOut !== {e, e} || Valid !== last || Full !== last
             || Dec !== {last, last}) begin
            bad++;
            $display("FAIL fill_%0d: out=%h v=%b f=%b dec=%b want %h %b %b %b",
                     i, DataOut, Valid, Full, Dec, {e, e}, last, last,
                     {last, last});
         end
      end
   endtask

   task automatic test_slide;
      logic [4:0] e;
      logic       d;
      for (int k = 1; k <= 16; k++) begin
         strobe(2'b00);
         e = 5'(16 - k);
         d = (k < 11);
         total++;
         if (DataOut !== {e, e} || Valid !== 1'b1 || Full !== 1'b1
             || Dec !== {d, d}) begin
            bad++;
            $display("FAIL slide_%0d: out=%h v=%b f=%b dec=%b want %h 1 1 %b",
                     k, DataOut, Valid, Full, Dec, {e, e}, {d, d});
         end
      end
   endtask

   task automatic test_hyst;
      logic [4:0] e;
      logic       d;
      for (int k = 1; k <= 10; k++) begin
         strobe(2'b11);
         e = 5'(k);
         d = (k == 10);
         total++;
         if (DataOut !== {e, e} || Dec !== {d, d}) begin
            bad++;
            $display("FAIL hyst_rise_%0d: out=%h dec=%b want %h %b",
                     k, DataOut, Dec, {e, e}, {d, d});
         end
      end
      // first six zeros push out zeros, next four push out ones
      for (int k = 1; k <= 10; k++) begin
         strobe(2'b00);
         e = (k <= 6) ? 5'd10 : 5'(16 - k);
         total++;
         if (DataOut !== {e, e} || Dec !== 2'b11) begin
            bad++;
            $display("FAIL hyst_hold_%0d: out=%h dec=%b want %h 11",
                     k, DataOut, Dec, {e, e});
         end
      end
   endtask

   task automatic test_gap_clr;
      logic [4:0] e;
      e = 5'd6;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         total++;
         if (DataOut !== {e, e} || Dec !== 2'b11 || Valid !== 1'b0
             || Full !== 1'b1) begin
            bad++;
            $display("FAIL gap_%0d: out=%h dec=%b v=%b f=%b want %h 11 0 1",
                     k, DataOut, Dec, Valid, Full, {e, e});
         end
      end
      @(negedge clk);
      clr = 1'b1;
      P = 1'b1;
      DataIn = 2'b11;
      @(posedge clk);
      #1;
      clr = 1'b0;
      P = 1'b0;
      total++;
      if ({DataOut, Dec, Valid, Full} !== '0) begin
         bad++;
         $display("FAIL clr_prio: out=%h dec=%b v=%b f=%b want 0",
                  DataOut, Dec, Valid, Full);
      end
      strobe(2'b11);
      e = 5'd1;
      total++;
      if (DataOut !== {e, e} || Full !== 1'b0 || Valid !== 1'b0) begin
         bad++;
         $display("FAIL after_clr: out=%h f=%b v=%b want %h 0 0",
                  DataOut, Full, Valid, {e, e});
      end
   endtask

   task automatic test_multi;
      logic [4:0] e0;
      logic [4:0] e1;
      logic       last;
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         strobe({(i % 2 == 0), 1'b1});
         e0 = 5'(i + 1);
         e1 = 5'((i + 2) / 2);
         last = (i == 15);
         total++;
         if (DataOut !== {e1, e0} || Valid !== last || Full !== last
             || Dec !== {1'b0, last}) begin
            bad++;
            $display("FAIL multi_%0d: out=%h v=%b f=%b dec=%b want %h %b %b %b",
                     i, DataOut, Valid, Full, Dec, {e1, e0}, last, last,
                     {1'b0, last});
         end
      end
      @(posedge clk);
      #1;
      total++;
      if (Valid !== 1'b0) begin
         bad++;
         $display("FAIL multi_pulse: valid=%b want 0", Valid);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_slide();
      test_hyst();
      test_gap_clr();
      test_multi();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
